// File: rtl/switch_pkg.sv
// Shared constants and width helpers for the address-routed N-port switch.
package switch_pkg;

   localparam int CLAMP_CNT_W = 8;

   // Occupancy counter must hold the value DEPTH itself, hence depth+1.
   function automatic int lvl_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/switch_if.sv
// Request-side and per-port output bundle of the N-port switch.
interface switch_if
   import switch_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int NUM_PORTS  = 4,
   parameter int FIFO_DEPTH = 4
);
   localparam int LEVEL_W = lvl_w(FIFO_DEPTH);

   logic                            in_vld;
   logic                            in_rdy;
   logic [ADDR_WIDTH-1:0]           addr;
   logic [DATA_WIDTH-1:0]           data;
   logic [NUM_PORTS-1:0]            out_vld;
   logic [NUM_PORTS-1:0]            out_rdy;
   logic [NUM_PORTS*ADDR_WIDTH-1:0] out_addr;
   logic [NUM_PORTS*DATA_WIDTH-1:0] out_data;
   logic [NUM_PORTS*LEVEL_W-1:0]    out_level;
   logic [CLAMP_CNT_W-1:0]          clamp_cnt;

   modport master (
      output in_vld, addr, data, out_rdy,
      input  in_rdy, out_vld, out_addr, out_data, out_level, clamp_cnt
   );

   modport slave (
      input  in_vld, addr, data, out_rdy,
      output in_rdy, out_vld, out_addr, out_data, out_level, clamp_cnt
   );

endinterface

// File: rtl/switch_fifo.sv
// First-word fall-through FIFO; head reads zero while empty, full/empty from an occupancy count.
module switch_fifo
   import switch_pkg::*;
#(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    push,
   input  logic [WIDTH-1:0]        din,
   output logic                    full,
   input  logic                    pop,
   output logic                    vld,
   output logic [WIDTH-1:0]        head,
   output logic [lvl_w(DEPTH)-1:0] level
);

   localparam int PTRW = ptr_w(DEPTH);
   localparam int LW   = lvl_w(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTRW-1:0]  rd_ptr;
   logic [PTRW-1:0]  wr_ptr;
   logic [LW-1:0]    count;
   logic             push_en;
   logic             pop_en;

   assign vld     = (count != '0);
   assign full    = (count == LW'(DEPTH));
   assign push_en = push & ~full;
   assign pop_en  = pop & vld;
   assign head    = vld ? mem[rd_ptr] : '0;
   assign level   = count;

   // Storage needs no reset: the head is masked whenever the count is zero.
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) begin
            wr_ptr <= wr_ptr + PTRW'(1);
         end
         if (pop_en) begin
            rd_ptr <= rd_ptr + PTRW'(1);
         end
         case ({push_en, pop_en})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/switch_nport.sv
// Steers one request stream to NUM_PORTS output FIFOs by address window, clamping
// out-of-range windows onto the last port and counting those clamped requests.
module switch_nport
   import switch_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int NUM_PORTS  = 4,
   parameter int PORT_SHIFT = 6,
   parameter int FIFO_DEPTH = 4
) (
   input  logic     clk,
   input  logic     rstn,
   switch_if.slave  bus
);

   localparam int PW = sel_w(NUM_PORTS);
   localparam int LW = lvl_w(FIFO_DEPTH);
   localparam int EW = ADDR_WIDTH + DATA_WIDTH;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   logic [ADDR_WIDTH-1:0]           idx;
   logic                            clamped;
   logic [PW-1:0]                   dest;
   logic                            in_rdy;
   logic                            accept;
   entry_t                          wr_entry;
   logic [NUM_PORTS-1:0]            full;
   logic [NUM_PORTS-1:0]            push;
   logic [NUM_PORTS-1:0]            vld;
   entry_t                          head  [NUM_PORTS];
   logic [LW-1:0]                   level [NUM_PORTS];
   logic [NUM_PORTS*ADDR_WIDTH-1:0] out_addr_w;
   logic [NUM_PORTS*DATA_WIDTH-1:0] out_data_w;
   logic [NUM_PORTS*LW-1:0]         out_level_w;
   logic [CLAMP_CNT_W-1:0]          clamp_cnt;

   // Routing is purely a function of addr so in_rdy never waits on in_vld.
   always_comb begin
      idx     = bus.addr >> PORT_SHIFT;
      clamped = (int'(idx) >= NUM_PORTS);
      dest    = clamped ? PW'(NUM_PORTS - 1) : idx[PW-1:0];
   end

   assign in_rdy        = ~full[dest];
   assign accept        = bus.in_vld & in_rdy;
   assign wr_entry.addr = bus.addr;
   assign wr_entry.data = bus.data;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign push[p] = accept & (dest == PW'(p));

      switch_fifo #(
         .WIDTH (EW),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rstn  (rstn),
         .push  (push[p]),
         .din   (wr_entry),
         .full  (full[p]),
         .pop   (bus.out_rdy[p]),
         .vld   (vld[p]),
         .head  (head[p]),
         .level (level[p])
      );

      assign out_addr_w[p*ADDR_WIDTH +: ADDR_WIDTH] = head[p].addr;
      assign out_data_w[p*DATA_WIDTH +: DATA_WIDTH] = head[p].data;
      assign out_level_w[p*LW +: LW]                = level[p];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         clamp_cnt <= '0;
      end else if (accept && clamped && (clamp_cnt != '1)) begin
         clamp_cnt <= clamp_cnt + CLAMP_CNT_W'(1);
      end
   end

   assign bus.in_rdy    = in_rdy;
   assign bus.out_vld   = vld;
   assign bus.out_addr  = out_addr_w;
   assign bus.out_data  = out_data_w;
   assign bus.out_level = out_level_w;
   assign bus.clamp_cnt = clamp_cnt;

endmodule

// File: tb/tb_switch_nport.sv
// Self-checking bench for switch_nport: directed scenarios plus randomized traffic
// compared against a per-port queue model.
module tb_switch_nport;

   localparam int AW = 8;
   localparam int DW = 16;
   localparam int NP = 4;
   localparam int DEPTH = 4;
   localparam int LW = 3;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   switch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP), .FIFO_DEPTH(DEPTH)) b ();
   switch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(3), .FIFO_DEPTH(DEPTH)) b3 ();

   switch_nport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP), .PORT_SHIFT(6), .FIFO_DEPTH(DEPTH))
      dut (.clk(clk), .rstn(rstn), .bus(b));
   switch_nport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(3), .PORT_SHIFT(6), .FIFO_DEPTH(DEPTH))
      dut3 (.clk(clk), .rstn(rstn), .bus(b3));

   int n_chk = 0;
   int n_pass = 0;

   // Reference model: one queue of {addr,data} per port, plus the clamp counter.
   logic [AW+DW-1:0] mq [NP][$];
   int mclamp = 0;
   bit last_acc;

   function automatic int route_idx(input logic [AW-1:0] a);
      return int'(a) / 64;
   endfunction

   function automatic int route(input logic [AW-1:0] a);
      int i;
      i = route_idx(a);
      return (i >= NP) ? NP - 1 : i;
   endfunction

   // One clock: decide accept/pops from pre-edge state, advance the model, return at negedge.
   task automatic tick();
      int d;
      bit [NP-1:0] pops;
      d = route(b.addr);
      last_acc = b.in_vld && (mq[d].size() < DEPTH);
      for (int p = 0; p < NP; p++) pops[p] = b.out_rdy[p] && (mq[p].size() > 0);
      @(posedge clk);
      for (int p = 0; p < NP; p++) if (pops[p]) void'(mq[p].pop_front());
      if (last_acc) begin
         mq[d].push_back({b.addr, b.data});
         if (route_idx(b.addr) >= NP && mclamp < 255) mclamp++;
      end
      @(negedge clk);
   endtask

   task automatic drive(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      b.in_vld = v;
      b.addr   = a;
      b.data   = d;
   endtask

   task automatic drain();
      b.in_vld = 1'b0;
      b.out_rdy = '1;
      repeat (DEPTH + 1) tick();
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      drive(1'b0, 8'h00, 16'h0000);
      b.out_rdy = '0;
      b3.in_vld = 1'b0; b3.addr = '0; b3.data = '0; b3.out_rdy = '1;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      drive(1'b1, 8'h05, 16'h1111);
      #1;
      n_chk++; if (b.in_rdy !== 1'b1) $display("FAIL reset_in_rdy got %b exp 1", b.in_rdy); else n_pass++;
      n_chk++; if (b.out_vld !== 4'h0) $display("FAIL reset_out_vld got %h exp 0", b.out_vld); else n_pass++;
      n_chk++; if (b.out_level !== '0) $display("FAIL reset_out_level got %h exp 0", b.out_level); else n_pass++;
      n_chk++; if (b.out_addr !== '0) $display("FAIL reset_out_addr got %h exp 0", b.out_addr); else n_pass++;
      n_chk++; if (b.out_data !== '0) $display("FAIL reset_out_data got %h exp 0", b.out_data); else n_pass++;
      n_chk++; if (b.clamp_cnt !== 8'h00) $display("FAIL reset_clamp_cnt got %h exp 0", b.clamp_cnt); else n_pass++;
      b.in_vld = 1'b0;
   endtask

   task automatic test_single();
      b.out_rdy = '1;
      drive(1'b1, 8'h05, 16'hAAAA);
      tick();
      n_chk++; if (b.out_vld !== 4'b0001) $display("FAIL single0_vld got %b exp 0001", b.out_vld); else n_pass++;
      n_chk++; if (b.out_addr !== 32'h0000_0005) $display("FAIL single0_addr got %h exp 00000005", b.out_addr); else n_pass++;
      n_chk++; if (b.out_data !== 64'h0000_0000_0000_AAAA) $display("FAIL single0_data got %h exp AAAA in port0", b.out_data); else n_pass++;
      drive(1'b1, 8'h45, 16'hBBBB);
      tick();
      n_chk++; if (b.out_vld !== 4'b0010) $display("FAIL single1_vld got %b exp 0010", b.out_vld); else n_pass++;
      n_chk++; if (b.out_addr !== 32'h0000_4500) $display("FAIL single1_addr got %h exp 00004500", b.out_addr); else n_pass++;
      n_chk++; if (b.out_data !== 64'h0000_0000_BBBB_0000) $display("FAIL single1_data got %h exp BBBB in port1", b.out_data); else n_pass++;
      b.in_vld = 1'b0;
      tick();
      n_chk++; if (b.out_vld !== 4'b0000) $display("FAIL single_idle_vld got %b exp 0000", b.out_vld); else n_pass++;
   endtask

   task automatic test_boundaries();
      logic [AW-1:0] addrs [5] = '{8'h3F, 8'h40, 8'hBF, 8'hC0, 8'hFF};
      int exp4 [5] = '{0, 1, 2, 3, 3};
      int exp3 [5] = '{0, 1, 2, 2, 2};
      int cl3  [5] = '{0, 0, 0, 1, 2};
      b.out_rdy = '1;
      b3.out_rdy = '1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, addrs[i], 16'(i + 16'h100));
         b3.in_vld = 1'b1; b3.addr = addrs[i]; b3.data = 16'(i);
         tick();
         n_chk++; if (b.out_vld !== 4'(1 << exp4[i]))
            $display("FAIL bound4_vld addr=%h got %b exp port %0d", addrs[i], b.out_vld, exp4[i]); else n_pass++;
         n_chk++; if (b.out_addr[exp4[i]*AW +: AW] !== addrs[i])
            $display("FAIL bound4_head addr=%h got %h", addrs[i], b.out_addr[exp4[i]*AW +: AW]); else n_pass++;
         n_chk++; if (b3.out_vld !== 3'(1 << exp3[i]))
            $display("FAIL bound3_vld addr=%h got %b exp port %0d", addrs[i], b3.out_vld, exp3[i]); else n_pass++;
         n_chk++; if (b3.clamp_cnt !== 8'(cl3[i]))
            $display("FAIL bound3_clamp addr=%h got %0d exp %0d", addrs[i], b3.clamp_cnt, cl3[i]); else n_pass++;
      end
      n_chk++; if (b.clamp_cnt !== 8'h00) $display("FAIL bound4_clamp got %0d exp 0", b.clamp_cnt); else n_pass++;
      b3.in_vld = 1'b0;
      drain();
   endtask

   task automatic test_fill();
      logic [DW-1:0] dat [4];
      b.out_rdy = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         dat[i] = 16'($urandom);
         drive(1'b1, 8'(8'h80 + i), dat[i]);
         tick();
      end
      n_chk++; if (b.out_level[2*LW +: LW] !== 3'd4) $display("FAIL fill_level got %0d exp 4", b.out_level[2*LW +: LW]); else n_pass++;
      drive(1'b0, 8'h90, 16'h0);
      #1;
      n_chk++; if (b.in_rdy !== 1'b0) $display("FAIL fill_rdy_full got %b exp 0", b.in_rdy); else n_pass++;
      drive(1'b1, 8'h10, 16'h5A5A);
      #1;
      n_chk++; if (b.in_rdy !== 1'b1) $display("FAIL fill_rdy_other got %b exp 1", b.in_rdy); else n_pass++;
      tick();
      n_chk++; if (b.out_vld[0] !== 1'b1 || b.out_addr[0 +: AW] !== 8'h10)
         $display("FAIL fill_port0 got vld=%b addr=%h exp vld=1 addr=10", b.out_vld[0], b.out_addr[0 +: AW]); else n_pass++;
      b.in_vld = 1'b0;
      b.out_rdy = '1;
      for (int i = 0; i < 4; i++) begin
         n_chk++; if (b.out_addr[2*AW +: AW] !== 8'(8'h80 + i) || b.out_data[2*DW +: DW] !== dat[i])
            $display("FAIL fill_order[%0d] got %h/%h exp %h/%h", i, b.out_addr[2*AW +: AW],
                     b.out_data[2*DW +: DW], 8'(8'h80 + i), dat[i]); else n_pass++;
         tick();
      end
      drain();
   endtask

   task automatic test_full_pop();
      b.out_rdy = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'(8'h80 + i), 16'(16'hC000 + i));
         tick();
      end
      b.out_rdy = 4'b1111;
      drive(1'b1, 8'h84, 16'hC004);
      #1;
      n_chk++; if (b.in_rdy !== 1'b0) $display("FAIL fullpop_rdy got %b exp 0", b.in_rdy); else n_pass++;
      tick();
      n_chk++; if (b.out_level[2*LW +: LW] !== 3'd3) $display("FAIL fullpop_level3 got %0d exp 3", b.out_level[2*LW +: LW]); else n_pass++;
      b.out_rdy = 4'b1011;
      #1;
      n_chk++; if (b.in_rdy !== 1'b1) $display("FAIL fullpop_rdy2 got %b exp 1", b.in_rdy); else n_pass++;
      tick();
      n_chk++; if (b.out_level[2*LW +: LW] !== 3'd4) $display("FAIL fullpop_level4 got %0d exp 4", b.out_level[2*LW +: LW]); else n_pass++;
      b.in_vld = 1'b0;
      b.out_rdy = '1;
      for (int i = 1; i < 5; i++) begin
         n_chk++; if (b.out_addr[2*AW +: AW] !== 8'(8'h80 + i))
            $display("FAIL fullpop_order[%0d] got %h exp %h", i, b.out_addr[2*AW +: AW], 8'(8'h80 + i)); else n_pass++;
         tick();
      end
      drain();
   endtask

   task automatic test_back_to_back();
      b.out_rdy = 4'b1101;
      drive(1'b1, 8'h40, 16'($urandom));
      tick();
      b.out_rdy = '1;
      for (int i = 1; i <= 20; i++) begin
         drive(1'b1, 8'h40 | 8'(i), 16'($urandom));
         tick();
         n_chk++; if (b.out_level[1*LW +: LW] !== 3'd1)
            $display("FAIL b2b_level[%0d] got %0d exp 1", i, b.out_level[1*LW +: LW]); else n_pass++;
         n_chk++; if ({b.out_addr[AW +: AW], b.out_data[DW +: DW]} !== mq[1][0] || mq[1][0][AW+DW-1 -: AW] !== (8'h40 | 8'(i)))
            $display("FAIL b2b_head[%0d] got %h exp %h", i, {b.out_addr[AW +: AW], b.out_data[DW +: DW]}, mq[1][0]); else n_pass++;
      end
      drain();
   endtask

   task automatic test_random();
      bit hold = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (!hold) drive(($urandom % 4) != 0, 8'($urandom), 16'($urandom));
         for (int p = 0; p < NP; p++) b.out_rdy[p] = ($urandom % 3) != 0;
         #1;
         n_chk++; if (b.in_rdy !== (mq[route(b.addr)].size() < DEPTH))
            $display("FAIL rand_in_rdy cyc=%0d addr=%h got %b", c, b.addr, b.in_rdy); else n_pass++;
         tick();
         hold = b.in_vld && !last_acc;
         for (int p = 0; p < NP; p++) begin
            logic [AW+DW-1:0] exp_head;
            exp_head = (mq[p].size() > 0) ? mq[p][0] : '0;
            n_chk++; if (b.out_vld[p] !== (mq[p].size() > 0))
               $display("FAIL rand_vld cyc=%0d p=%0d got %b exp size %0d", c, p, b.out_vld[p], mq[p].size()); else n_pass++;
            n_chk++; if (b.out_addr[p*AW +: AW] !== exp_head[AW+DW-1 -: AW])
               $display("FAIL rand_addr cyc=%0d p=%0d got %h exp %h", c, p, b.out_addr[p*AW +: AW], exp_head[AW+DW-1 -: AW]); else n_pass++;
            n_chk++; if (b.out_data[p*DW +: DW] !== exp_head[DW-1:0])
               $display("FAIL rand_data cyc=%0d p=%0d got %h exp %h", c, p, b.out_data[p*DW +: DW], exp_head[DW-1:0]); else n_pass++;
            n_chk++; if (b.out_level[p*LW +: LW] !== LW'(mq[p].size()))
               $display("FAIL rand_level cyc=%0d p=%0d got %0d exp %0d", c, p, b.out_level[p*LW +: LW], mq[p].size()); else n_pass++;
         end
         n_chk++; if (b.clamp_cnt !== 8'(mclamp))
            $display("FAIL rand_clamp cyc=%0d got %0d exp %0d", c, b.clamp_cnt, mclamp); else n_pass++;
      end
      if (hold) tick();
      drain();
   endtask

   task automatic test_reset_mid();
      logic [AW-1:0] fill [6] = '{8'h00, 8'h01, 8'h80, 8'h81, 8'h82, 8'hC0};
      b.out_rdy = '0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, fill[i], 16'($urandom));
         tick();
      end
      n_chk++; if (b.out_level !== {3'd1, 3'd3, 3'd0, 3'd2})
         $display("FAIL midrst_pre_level got %h exp %h", b.out_level, {3'd1, 3'd3, 3'd0, 3'd2}); else n_pass++;
      drive(1'b1, 8'h41, 16'h7777);
      #2 rstn = 1'b0;
      #1;
      n_chk++; if (b.out_vld !== 4'h0) $display("FAIL midrst_vld got %b exp 0000", b.out_vld); else n_pass++;
      n_chk++; if (b.out_level !== '0) $display("FAIL midrst_level got %h exp 0", b.out_level); else n_pass++;
      n_chk++; if (b.out_addr !== '0 || b.out_data !== '0)
         $display("FAIL midrst_head got %h/%h exp 0/0", b.out_addr, b.out_data); else n_pass++;
      n_chk++; if (b3.clamp_cnt !== 8'h00) $display("FAIL midrst_clamp got %0d exp 0", b3.clamp_cnt); else n_pass++;
      b.in_vld = 1'b0;
      for (int p = 0; p < NP; p++) mq[p].delete();
      mclamp = 0;
      @(negedge clk);
      rstn = 1'b1;
      b.out_rdy = '1;
      drive(1'b1, 8'h05, 16'h1234);
      #1;
      n_chk++; if (b.in_rdy !== 1'b1) $display("FAIL postrst_rdy got %b exp 1", b.in_rdy); else n_pass++;
      tick();
      n_chk++; if (b.out_vld !== 4'b0001 || b.out_data[0 +: DW] !== 16'h1234)
         $display("FAIL postrst_write got vld=%b data=%h exp 0001/1234", b.out_vld, b.out_data[0 +: DW]); else n_pass++;
      b.in_vld = 1'b0;
      drain();
   endtask

   initial begin
      test_reset();
      test_single();
      test_boundaries();
      test_fill();
      test_full_pop();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
